// File: rtl/run_pkg.sv
// Shared types and default parameters for the run sequencer.
package run_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    LAUNCH,
    RUN,
    FIN
  } run_state_t;

  localparam int DEF_NUM_PROGS  = 3;
  localparam int DEF_RST_CYCLES = 2;
  localparam int DEF_TIMEOUT    = 100000;
  localparam int DEF_CYC_W      = 32;

endpackage

// File: rtl/run_sequencer_cycle_counter.sv
// Up-counter with synchronous clear; clear has priority over enable.
module cycle_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/run_sequencer.sv
// Run controller: for each program resets the core, launches it, watches for
// completion under a cycle watchdog and reports the per-program RUN cycle count.
module run_sequencer
  import run_pkg::*;
#(
  parameter  int NUM_PROGS  = DEF_NUM_PROGS,
  parameter  int RST_CYCLES = DEF_RST_CYCLES,
  parameter  int TIMEOUT    = DEF_TIMEOUT,
  parameter  int CYC_W      = DEF_CYC_W,
  localparam int PROG_W     = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  output logic              core_reset,
  output logic              core_req,
  input  logic              core_done,
  output logic [PROG_W-1:0] prog_sel,
  output logic              busy,
  output logic              res_valid,
  output logic [PROG_W-1:0] res_prog,
  output logic [CYC_W-1:0]  res_cycles,
  output logic              done,
  output logic              timeout
);

  localparam int RST_W = $clog2(RST_CYCLES + 1);

  run_state_t state_reg, state_next;
  logic [PROG_W-1:0] prog_reg, prog_next;
  logic done_reg, done_next;
  logic timeout_reg, timeout_next;
  logic res_valid_reg, res_valid_next;
  logic [PROG_W-1:0] res_prog_reg, res_prog_next;
  logic [CYC_W-1:0] res_cycles_reg, res_cycles_next;

  logic rst_clr, rst_en, run_clr, run_en;
  logic [RST_W-1:0] rst_count;
  logic [CYC_W-1:0] run_count;
  logic [CYC_W-1:0] run_now;

  cycle_counter #(.W(RST_W)) u_rst_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (rst_clr),
    .en    (rst_en),
    .count (rst_count)
  );

  cycle_counter #(.W(CYC_W)) u_run_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (run_clr),
    .en    (run_en),
    .count (run_count)
  );

  // Register holds completed RUN cycles; the current cycle is included here.
  assign run_now = run_count + CYC_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      prog_reg       <= '0;
      done_reg       <= 1'b0;
      timeout_reg    <= 1'b0;
      res_valid_reg  <= 1'b0;
      res_prog_reg   <= '0;
      res_cycles_reg <= '0;
    end else begin
      state_reg      <= state_next;
      prog_reg       <= prog_next;
      done_reg       <= done_next;
      timeout_reg    <= timeout_next;
      res_valid_reg  <= res_valid_next;
      res_prog_reg   <= res_prog_next;
      res_cycles_reg <= res_cycles_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    prog_next       = prog_reg;
    done_next       = done_reg;
    timeout_next    = timeout_reg;
    res_valid_next  = 1'b0;
    res_prog_next   = res_prog_reg;
    res_cycles_next = res_cycles_reg;
    rst_clr         = 1'b0;
    rst_en          = 1'b0;
    run_clr         = 1'b0;
    run_en          = 1'b0;

    case (state_reg)
      IDLE: begin
        if (req) begin
          state_next   = RST;
          prog_next    = '0;
          done_next    = 1'b0;
          timeout_next = 1'b0;
          rst_clr      = 1'b1;
        end
      end
      RST: begin
        rst_en = 1'b1;
        if (rst_count == RST_W'(RST_CYCLES - 1)) begin
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        run_clr    = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        run_en = 1'b1;
        // Completion is checked first so it wins over a same-cycle watchdog expiry.
        if (core_done) begin
          res_valid_next  = 1'b1;
          res_prog_next   = prog_reg;
          res_cycles_next = run_now;
          if (prog_reg == PROG_W'(NUM_PROGS - 1)) begin
            state_next = FIN;
            done_next  = 1'b1;
          end else begin
            prog_next  = prog_reg + PROG_W'(1);
            state_next = RST;
            rst_clr    = 1'b1;
          end
        end else if (run_now == CYC_W'(TIMEOUT)) begin
          timeout_next = 1'b1;
          done_next    = 1'b1;
          state_next   = FIN;
        end
      end
      FIN: begin
        // done is raised on entry so it coincides with the last res_valid.
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign core_reset = reset | (state_reg == RST);
  assign core_req   = (state_reg == LAUNCH);
  assign busy       = (state_reg != IDLE);
  assign prog_sel   = prog_reg;
  assign done       = done_reg;
  assign timeout    = timeout_reg;
  assign res_valid  = res_valid_reg;
  assign res_prog   = res_prog_reg;
  assign res_cycles = res_cycles_reg;

endmodule

// File: tb/tb_run_sequencer.sv
// Randomized scoreboard bench for run_sequencer with a simple core model.
module tb_run_sequencer;

  localparam int NP = 3;
  localparam int RC = 2;
  localparam int TO = 10;
  localparam int CW = 32;
  localparam int PW = 2;

  logic clk = 1'b0;
  logic reset, req, core_done;
  logic core_reset, core_req, busy, res_valid, done, timeout;
  logic [PW-1:0] prog_sel, res_prog;
  logic [CW-1:0] res_cycles;

  always #5 clk = ~clk;

  run_sequencer #(
    .NUM_PROGS  (NP),
    .RST_CYCLES (RC),
    .TIMEOUT    (TO),
    .CYC_W      (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .core_reset (core_reset),
    .core_req   (core_req),
    .core_done  (core_done),
    .prog_sel   (prog_sel),
    .busy       (busy),
    .res_valid  (res_valid),
    .res_prog   (res_prog),
    .res_cycles (res_cycles),
    .done       (done),
    .timeout    (timeout)
  );

  typedef struct {
    int prog;
    int cyc;
  } res_t;

  res_t exp_q[$];
  bit   exp_to_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each program either completes within the watchdog or aborts the rest.
  task automatic model(input int d[3]);
    bit to;
    to = 1'b0;
    for (int i = 0; i < NP; i++) begin
      if (d[i] >= 1 && d[i] <= TO) begin
        exp_q.push_back('{prog: i, cyc: d[i]});
      end else begin
        to = 1'b1;
        break;
      end
    end
    exp_to_q.push_back(to);
  endtask

  // Monitor
  bit   done_q = 1'b0;
  int   rst_run = 0;
  res_t mon_e;
  bit   mon_to;

  always @(negedge clk) begin
    if (reset) begin
      rst_run = 0;
    end else begin
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          check("res_unexpected", res_valid, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("res_prog", res_prog, mon_e.prog);
          check("res_cycles", res_cycles, mon_e.cyc);
          $display("result prog=%0d cycles=%0d", res_prog, res_cycles);
        end
      end
      if (done && !done_q) begin
        if (exp_to_q.size() == 0) begin
          check("done_unexpected", done, 0);
        end else begin
          mon_to = exp_to_q.pop_front();
          check("timeout", timeout, mon_to);
          if (!mon_to) check("last_res_with_done", res_valid, 1);
          $display("sequence done timeout=%0d", timeout);
        end
      end
      if (core_req) check("rst_cycles_before_launch", rst_run, RC);
      if (core_reset) rst_run++;
      else rst_run = 0;
    end
    done_q = done;
  end

  task automatic idle(input int n);
    logic d0, t0;
    d0 = done;
    t0 = timeout;
    for (int i = 0; i < n; i++) begin
      req       = 1'b0;
      core_done = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_done_hold", done, d0);
      check("idle_timeout_hold", timeout, t0);
    end
    core_done = 1'b0;
  endtask

  task automatic run_seq(input int a, input int b, input int c);
    int d[3];
    int k, p;
    bit fin;
    d[0] = a; d[1] = b; d[2] = c;
    model(d);
    @(negedge clk);
    req = 1'b1;
    core_done = 1'b0;
    @(negedge clk);
    req = 1'b0;
    check("accept_done", done, 0);
    check("accept_timeout", timeout, 0);
    check("accept_prog", prog_sel, 0);
    check("accept_busy", busy, 1);
    k = -1;
    p = -1;
    fin = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (done) begin
        fin = 1'b1;
        break;
      end
      if (core_req) begin
        p++;
        k = 0;
        core_done = 1'($urandom_range(0, 1));
      end else if (k >= 0) begin
        k++;
        if (p < NP && k == d[p]) begin
          core_done = 1'b1;
          k = -1;
        end else begin
          core_done = 1'b0;
        end
      end else begin
        core_done = 1'($urandom_range(0, 1));
      end
      req = ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    check("seq_finished_in_budget", fin, 1);
    req = 1'b0;
    core_done = 1'b0;
  endtask

  task automatic reset_mid();
    int d[3];
    int k, p;
    d[0] = 3; d[1] = 0; d[2] = 0;
    exp_q.push_back('{prog: 0, cyc: 3});
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    k = -1;
    p = -1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (core_req) begin
        p++;
        k = 0;
        core_done = 1'b0;
      end else if (k >= 0) begin
        k++;
        core_done = (p == 0 && k == d[0]);
        if (p == 0 && k == d[0]) k = -1;
        if (p == 1 && k == 3) break;
      end else begin
        core_done = 1'b0;
      end
      @(negedge clk);
    end
    check("mid_in_run_prog1", prog_sel, 1);
    reset = 1'b1;
    core_done = 1'b0;
    @(negedge clk);
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    check("mid_prog", prog_sel, 0);
    check("mid_core_reset", core_reset, 1);
    check("mid_res_valid", res_valid, 0);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("mid_after_done", done, 0);
      check("mid_after_busy", busy, 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    req = 1'b0;
    core_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_core_reset", core_reset, 1);
      check("rst_busy", busy, 0);
      check("rst_core_req", core_req, 0);
    end
    reset = 1'b0;
    @(negedge clk);
    check("rel_core_reset", core_reset, 0);
    check("rel_core_req", core_req, 0);
    check("rel_busy", busy, 0);
    check("rel_res_valid", res_valid, 0);
    check("rel_res_cycles", res_cycles, 0);
    check("rel_res_prog", res_prog, 0);
    check("rel_prog_sel", prog_sel, 0);
    check("rel_done", done, 0);
    check("rel_timeout", timeout, 0);
    idle(3);

    run_seq(5, 1, 7);   idle(3);
    run_seq(4, 0, 3);   idle(2);
    run_seq(10, 10, 10); idle(2);
    run_seq(1, 1, 1);   idle(1);
    run_seq(11, 2, 3);  idle(2);
    for (int s = 0; s < 25; s++) begin
      run_seq($urandom_range(1, 12), $urandom_range(1, 12), $urandom_range(1, 12));
      idle($urandom_range(1, 3));
    end
    reset_mid();

    check("exp_results_drained", exp_q.size(), 0);
    check("exp_done_drained", exp_to_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
